ibex_fp_rf_wr_arb: RTL and testbench
====================================

# ibex_fp_rf_wr_arb

FP register-file write-port arbiter and FPU result buffer, placed directly downstream of the writeback stage. The FP register file has one write port. That port is shared by two sources: LSU-to-FP load writes coming out of writeback, and results from the multi-cycle FPU. Writeback writes always win; FPU results that lose arbitration are held in an in-order queue and drained in free cycles. The block also reports queued-but-unwritten destinations to ID/EX for hazard stalls.

## Interface
- Depth, 2, FPU result queue entries; legal 2..8.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- wb_we_fp_i  in  1  FP write from writeback (load data destined for FP RF); cannot be stalled.
- wb_waddr_i  in  5  writeback destination register.
- wb_wdata_i  in  32  writeback data.
- fpu_valid_i  in  1  FPU result valid.
- fpu_ready_o  out  1  block can accept an FPU result this cycle.
- fpu_waddr_i  in  5  FPU destination register.
- fpu_wdata_i  in  32  FPU result data.
- rf_we_fp_o  out  1  FP RF write enable.
- rf_waddr_fp_o  out  5  FP RF write address.
- rf_wdata_fp_o  out  32  FP RF write data.
- raddr_a_i / raddr_b_i / raddr_c_i  in  5 each  FP operand read addresses from ID.
- pending_a_o / pending_b_o / pending_c_o  out  1 each  the matching read address has a live queued write.
- queue_empty_o  out  1  no entries held.

## Operation
- Queue: circular FIFO of Depth entries, each {live, waddr, wdata}. Read and write pointers use $clog2(Depth) bits and wrap modulo Depth. The count field is $clog2(Depth)+1 bits.
- Write-port priority each cycle:
  1. wb_we_fp_i=1: the port drives the wb_* values. No drain.
  2. Otherwise, queue non-empty: pop the head. rf_we_fp_o equals the head's live bit; address and data come from the head.
  3. Otherwise, accepted FPU result: bypass straight to the port. It is not enqueued.
  4. Otherwise: rf_we_fp_o=0.
- fpu_ready_o = (count < Depth). It depends only on state and does not look ahead at a same-cycle drain.
- Accept = fpu_valid_i & fpu_ready_o. An accepted result is enqueued unless case 3 applies.
- Enqueue and pop in the same cycle leave count unchanged.
- WAW kill:
  - When wb_we_fp_i=1, every queued entry with waddr == wb_waddr_i has its live bit cleared that cycle.
  - A killed entry still occupies its slot. When it reaches the head it is popped with rf_we_fp_o=0.
  - An FPU result accepted in the same cycle as the wb write is younger. It is enqueued live even if the addresses match.
- Hazard outputs:
  - pending_x_o = OR over queued entries of (live & waddr == raddr_x_i).
  - They are combinational from state and raddr only.
  - A bypassing result never raises pending.
- queue_empty_o = (count == 0).
- Data integrity: the block never reorders FPU results, and never drops a live result except through a WAW kill.
- Assertion: count never exceeds Depth.

## Timing
- Reset (async assert, release on a clock edge):
  - count=0, pointers=0, all live bits 0.
  - fpu_ready_o=1, queue_empty_o=1, pending_*=0.
  - rf_we_fp_o reflects only wb_we_fp_i.
- Latency:
  - Bypass: 0 cycles (input to port in the same cycle).
  - Queued result: written no earlier than the cycle after acceptance. Written in the first cycle in which wb_we_fp_i=0 and it is at the head.
- Full: with count==Depth, fpu_ready_o=0 even if a pop occurs that cycle. Ready rises the cycle after the pop.
- Wrap-around: pointers roll from Depth-1 to 0 with no bubble.
- Reset mid-operation: all queued entries are discarded and are never written.

## Test plan
- Bypass: empty queue; fpu_valid_i=1, addr 5, data 0x3F800000.
  -> Same cycle: rf_we_fp_o=1, addr 5, data 0x3F800000. queue_empty_o stays 1.
- Collision: cycle 0 has wb write f2/0xAAAA5555 and FPU f7/0x00001234.
  -> Cycle 0 writes f2; cycle 1 writes f7/0x00001234; queue empty in cycle 2.
- Full/backpressure (Depth=2): wb_we_fp_i held high 4 cycles; FPU results f1, f2, f3 offered each cycle.
  -> f1 and f2 accepted; fpu_ready_o=0 from cycle 2.
  -> After wb drops: f1, then f2 written. f3 accepted after ready rises. Order is f1, f2, f3.
- WAW kill: queue holds f4/0x11111111 while wb writes f4/0x55555555.
  -> Drain slot shows rf_we_fp_o=0. Final f4 = 0x55555555. pending_a_o (raddr_a_i=4) drops the cycle after the wb write.
- Pending: queue holds f9, raddr_b_i=9.
  -> pending_b_o=1 until the drain cycle, then 0 the next cycle. raddr_b_i=8 gives 0 throughout.
- Reset mid-operation: two queued entries; pulse rst_i.
  -> Immediately: queue_empty_o=1, fpu_ready_o=1, pending_*=0.
  -> No rf_we_fp_o for the discarded entries afterwards.

Source files
------------

// File: rtl/ibex_fp_rf_wr_arb.sv
// FP register-file write-port arbiter: writeback loads win, FPU results
// bypass or wait in an in-order queue with WAW kill and hazard reporting.
module ibex_fp_rf_wr_arb #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_we_fp_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_wdata_i,
    input  logic        fpu_valid_i,
    output logic        fpu_ready_o,
    input  logic [4:0]  fpu_waddr_i,
    input  logic [31:0] fpu_wdata_i,
    output logic        rf_we_fp_o,
    output logic [4:0]  rf_waddr_fp_o,
    output logic [31:0] rf_wdata_fp_o,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    input  logic [4:0]  raddr_c_i,
    output logic        pending_a_o,
    output logic        pending_b_o,
    output logic        pending_c_o,
    output logic        queue_empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    logic [DEPTH-1:0] r_live;
    logic [4:0]       r_waddr [DEPTH];
    logic [31:0]      r_wdata [DEPTH];
    logic [AW-1:0]    r_rptr;
    logic [AW-1:0]    r_wptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_accept;
    logic w_pop;
    logic w_bypass;
    logic w_push;

    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    assign w_empty       = (r_count == '0);
    assign fpu_ready_o   = (r_count < DEPTH_C);
    assign queue_empty_o = w_empty;
    assign w_accept      = fpu_valid_i & fpu_ready_o;
    assign w_pop         = ~wb_we_fp_i & ~w_empty;
    assign w_bypass      = ~wb_we_fp_i & w_empty & w_accept;
    assign w_push        = w_accept & ~w_bypass;

    always_comb begin
        rf_we_fp_o    = 1'b0;
        rf_waddr_fp_o = wb_waddr_i;
        rf_wdata_fp_o = wb_wdata_i;
        if (wb_we_fp_i) begin
            rf_we_fp_o = 1'b1;
        end else if (!w_empty) begin
            // killed heads still drain, just without a write
            rf_we_fp_o    = r_live[r_rptr];
            rf_waddr_fp_o = r_waddr[r_rptr];
            rf_wdata_fp_o = r_wdata[r_rptr];
        end else if (w_accept) begin
            rf_we_fp_o    = 1'b1;
            rf_waddr_fp_o = fpu_waddr_i;
            rf_wdata_fp_o = fpu_wdata_i;
        end
    end

    always_comb begin
        pending_a_o = 1'b0;
        pending_b_o = 1'b0;
        pending_c_o = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_live[i] && r_waddr[i] == raddr_a_i) pending_a_o = 1'b1;
            if (r_live[i] && r_waddr[i] == raddr_b_i) pending_b_o = 1'b1;
            if (r_live[i] && r_waddr[i] == raddr_c_i) pending_c_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_live  <= '0;
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_waddr[i] <= '0;
                r_wdata[i] <= '0;
            end
        end else begin
            // kill first so a same-cycle (younger) enqueue stays live
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (wb_we_fp_i && r_waddr[i] == wb_waddr_i) r_live[i] <= 1'b0;
            end
            if (w_pop) begin
                r_live[r_rptr] <= 1'b0;
                r_rptr         <= f_inc(r_rptr);
            end
            if (w_push) begin
                r_live[r_wptr]  <= 1'b1;
                r_waddr[r_wptr] <= fpu_waddr_i;
                r_wdata[r_wptr] <= fpu_wdata_i;
                r_wptr          <= f_inc(r_wptr);
            end
            if (w_push && !w_pop) r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        r_count <= DEPTH_C);

endmodule

// File: tb/tb_ibex_fp_rf_wr_arb.sv
// Randomised bench for ibex_fp_rf_wr_arb against a queue-based
// reference model of the write-port arbitration rules.
module tb_ibex_fp_rf_wr_arb;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        wb_we_fp_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        fpu_valid_i;
    logic        fpu_ready_o;
    logic [4:0]  fpu_waddr_i;
    logic [31:0] fpu_wdata_i;
    logic        rf_we_fp_o;
    logic [4:0]  rf_waddr_fp_o;
    logic [31:0] rf_wdata_fp_o;
    logic [4:0]  raddr_a_i, raddr_b_i, raddr_c_i;
    logic        pending_a_o, pending_b_o, pending_c_o;
    logic        queue_empty_o;

    always #5 clk = ~clk;

    ibex_fp_rf_wr_arb #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .wb_we_fp_i   (wb_we_fp_i),
        .wb_waddr_i   (wb_waddr_i),
        .wb_wdata_i   (wb_wdata_i),
        .fpu_valid_i  (fpu_valid_i),
        .fpu_ready_o  (fpu_ready_o),
        .fpu_waddr_i  (fpu_waddr_i),
        .fpu_wdata_i  (fpu_wdata_i),
        .rf_we_fp_o   (rf_we_fp_o),
        .rf_waddr_fp_o(rf_waddr_fp_o),
        .rf_wdata_fp_o(rf_wdata_fp_o),
        .raddr_a_i    (raddr_a_i),
        .raddr_b_i    (raddr_b_i),
        .raddr_c_i    (raddr_c_i),
        .pending_a_o  (pending_a_o),
        .pending_b_o  (pending_b_o),
        .pending_c_o  (pending_c_o),
        .queue_empty_o(queue_empty_o)
    );

    typedef struct {
        bit          live;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] rf_dut [32];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit we, input logic [4:0] wa,
                        input logic [31:0] wd, input bit fv,
                        input logic [4:0] fa, input logic [31:0] fd,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] rc);
        bit rdy, acc, byp, pop, ewe, pa, pb, pc;
        logic [4:0]  ea;
        logic [31:0] ed;
        @(posedge clk);
        #1;
        wb_we_fp_i  = we;
        wb_waddr_i  = wa;
        wb_wdata_i  = wd;
        fpu_valid_i = fv;
        fpu_waddr_i = fa;
        fpu_wdata_i = fd;
        raddr_a_i   = ra;
        raddr_b_i   = rb;
        raddr_c_i   = rc;
        @(negedge clk);
        rdy = (q.size() < DEPTH);
        acc = fv && rdy;
        byp = 0; pop = 0; ewe = 0; ea = '0; ed = '0;
        if (we) begin
            ewe = 1; ea = wa; ed = wd;
        end else if (q.size() > 0) begin
            pop = 1; ewe = q[0].live; ea = q[0].a; ed = q[0].d;
        end else if (acc) begin
            byp = 1; ewe = 1; ea = fa; ed = fd;
        end
        pa = 0; pb = 0; pc = 0;
        foreach (q[i]) begin
            if (q[i].live && q[i].a == ra) pa = 1;
            if (q[i].live && q[i].a == rb) pb = 1;
            if (q[i].live && q[i].a == rc) pc = 1;
        end
        chk("rf_we", 32'(rf_we_fp_o), 32'(ewe));
        if (ewe) begin
            chk("rf_waddr", 32'(rf_waddr_fp_o), 32'(ea));
            chk("rf_wdata", rf_wdata_fp_o, ed);
        end
        chk("fpu_ready", 32'(fpu_ready_o), 32'(rdy));
        chk("queue_empty", 32'(queue_empty_o), 32'(q.size() == 0));
        chk("pending_a", 32'(pending_a_o), 32'(pa));
        chk("pending_b", 32'(pending_b_o), 32'(pb));
        chk("pending_c", 32'(pending_c_o), 32'(pc));
        if (rf_we_fp_o) rf_dut[rf_waddr_fp_o] = rf_wdata_fp_o;
        if (we) foreach (q[i]) if (q[i].a == wa) q[i].live = 0;
        if (pop) void'(q.pop_front());
        if (acc && !byp) q.push_back('{1'b1, fa, fd});
    endtask

    task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, ra, rb, 5'd31);
    endtask

    task automatic pulse_reset(input bit we);
        @(posedge clk);
        #1;
        rst_i       = 1'b1;
        wb_we_fp_i  = we;
        fpu_valid_i = 1'b0;
        #1;
        q.delete();
        chk("rst_empty", 32'(queue_empty_o), 32'd1);
        chk("rst_ready", 32'(fpu_ready_o), 32'd1);
        chk("rst_pend", 32'({pending_a_o, pending_b_o, pending_c_o}), 32'd0);
        chk("rst_we", 32'(rf_we_fp_o), 32'(we));
        @(posedge clk);
        #1;
        rst_i      = 1'b0;
        wb_we_fp_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        wb_we_fp_i  = 1'b0;
        wb_waddr_i  = '0;
        wb_wdata_i  = '0;
        fpu_valid_i = 1'b0;
        fpu_waddr_i = '0;
        fpu_wdata_i = '0;
        raddr_a_i   = '0;
        raddr_b_i   = '0;
        raddr_c_i   = '0;
        for (int i = 0; i < 32; i++) rf_dut[i] = '0;
        @(negedge clk);
        chk("init_empty", 32'(queue_empty_o), 32'd1);
        chk("init_ready", 32'(fpu_ready_o), 32'd1);
        chk("init_we", 32'(rf_we_fp_o), 32'd0);
        chk("init_pend", 32'({pending_a_o, pending_b_o, pending_c_o}), 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // bypass into an empty queue
        step(0, 5'd0, 32'd0, 1, 5'd5, 32'h3F800000, 5'd5, 5'd0, 5'd0);
        chk("byp_data", rf_wdata_fp_o, 32'h3F800000);

        // collision: wb wins, FPU result follows next cycle
        step(1, 5'd2, 32'hAAAA5555, 1, 5'd7, 32'h00001234, 5'd7, 5'd2, 5'd0);
        idle(5'd7, 5'd2);
        chk("coll_f7", rf_dut[7], 32'h00001234);
        idle(5'd7, 5'd2);
        chk("coll_empty", 32'(queue_empty_o), 32'd1);

        // full and backpressure with wb holding the port
        for (int k = 0; k < 4; k++)
            step(1, 5'(20 + k), 32'(k), 1, (k < 2) ? 5'(k + 1) : 5'd3,
                 32'(16'hF000 + ((k < 2) ? k + 1 : 3)), 5'd1, 5'd2, 5'd3);
        for (int k = 0; k < 4; k++)
            step(0, 5'd0, 32'd0, 1, 5'd3, 32'h0000F003, 5'd1, 5'd2, 5'd3);
        chk("full_f3", rf_dut[3], 32'h0000F003);
        idle(5'd0, 5'd0);

        // WAW kill of a queued f4
        step(1, 5'd0, 32'd0, 1, 5'd4, 32'h11111111, 5'd4, 5'd0, 5'd0);
        step(1, 5'd4, 32'h55555555, 0, 5'd0, 32'd0, 5'd4, 5'd0, 5'd0);
        idle(5'd4, 5'd0);
        idle(5'd4, 5'd0);
        chk("waw_f4", rf_dut[4], 32'h55555555);

        // pending on f9 until drained
        step(1, 5'd0, 32'd0, 1, 5'd9, 32'h99, 5'd0, 5'd9, 5'd8);
        step(1, 5'd1, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd9, 5'd8);
        idle(5'd8, 5'd9);
        idle(5'd8, 5'd9);

        // reset with two queued entries
        step(1, 5'd0, 32'd0, 1, 5'd12, 32'hC0C0, 5'd12, 5'd13, 5'd0);
        step(1, 5'd0, 32'd0, 1, 5'd13, 32'hD0D0, 5'd12, 5'd13, 5'd0);
        pulse_reset(1'b0);
        for (int k = 0; k < 3; k++) idle(5'd12, 5'd13);

        // randomised traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset(1'($urandom_range(0, 1)));
            end else begin
                step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                     $urandom, $urandom_range(0, 9) < 6,
                     5'($urandom_range(0, 7)), $urandom,
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
